aes_apb_host_if: RTL

APB slave front end of the AES IP that turns host register accesses into the datapath's host-side controls. It drives `bus_in`, the one-hot write enables for columns, key and IV, and the read selects. It sequences four-word block input and output, and pulses `start` to the control unit. It also keeps the status and interrupt flags, based on `end_aes`.

---
 rtl/aes_apb_host_if_pkg.sv | 59 +++++
 rtl/aes_apb_host_if_word_seq.sv | 24 ++
 rtl/aes_apb_host_if.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/aes_apb_host_if_pkg.sv
// Shared register map for the AES APB host interface: word indices, CR/SR bit
// positions, MODE encodings and the CR field bundle.
package aes_apb_host_if_pkg;

  localparam logic [3:0] IDX_CR    = 4'd0;
  localparam logic [3:0] IDX_SR    = 4'd1;
  localparam logic [3:0] IDX_DINR  = 4'd2;
  localparam logic [3:0] IDX_DOUTR = 4'd3;
  // Upper two bits of the word index select the four-word key and IV banks
  localparam logic [1:0] GRP_KEYR  = 2'b01;
  localparam logic [1:0] GRP_IVR   = 2'b10;

  localparam int CR_EN       = 0;
  localparam int CR_DATATYPE = 1;
  localparam int CR_MODE     = 3;
  localparam int CR_ENCDEC   = 5;
  localparam int CR_CCFC     = 7;
  localparam int CR_ERRC     = 8;
  localparam int CR_CCFIE    = 9;
  localparam int CR_ERRIE    = 10;

  localparam int SR_CCF   = 0;
  localparam int SR_RDERR = 1;
  localparam int SR_WRERR = 2;
  localparam int SR_BUSY  = 3;

  typedef enum logic [1:0] {
    MODE_ECB = 2'b00,
    MODE_CBC = 2'b01,
    MODE_CTR = 2'b10
  } mode_e;

  typedef struct packed {
    logic       errie;
    logic       ccfie;
    logic       enc_dec;
    mode_e      mode;
    logic [1:0] data_type;
    logic       en;
  } cr_t;

  // CCFC and ERRC are write-only strobes, so they always read back as 0
  function automatic logic [31:0] cr_word(input cr_t c);
    logic [31:0] w;
    w                     = '0;
    w[CR_EN]              = c.en;
    w[CR_DATATYPE +: 2]   = c.data_type;
    w[CR_MODE +: 2]       = c.mode;
    w[CR_ENCDEC]          = c.enc_dec;
    w[CR_CCFIE]           = c.ccfie;
    w[CR_ERRIE]           = c.errie;
    return w;
  endfunction

  function automatic logic [3:0] onehot4(input logic [1:0] i);
    return 4'b0001 << i;
  endfunction

endpackage

// File: rtl/aes_apb_host_if_word_seq.sv
// Two-bit wrapping word counter used to sequence the four words of a block,
// with one-hot decode and a pulse on the increment that wraps 3 -> 0.
module word_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  output logic [1:0] cnt,
  output logic [3:0] onehot,
  output logic       wrap
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= cnt + 2'd1;
  end

  assign onehot = 4'b0001 << cnt;
  assign wrap   = inc & (cnt == 2'd3);

endmodule

// File: rtl/aes_apb_host_if.sv
// APB slave front end of the AES IP: decodes host accesses into datapath
// enables, sequences block input/output words and keeps status/interrupt flags.
module aes_apb_host_if
  import aes_apb_host_if_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [5:0]  paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic [31:0] bus_in,
  input  logic [31:0] col_bus,
  input  logic [31:0] iv_bus,
  input  logic        end_aes,
  output logic [3:0]  col_en_host,
  output logic [3:0]  key_host_en,
  output logic [3:0]  iv_en,
  output logic [3:0]  iv_sel_rd,
  output logic [1:0]  col_sel_host,
  output logic [1:0]  key_sel_rd,
  output logic [1:0]  data_type,
  output logic [1:0]  mode,
  output logic        enc_dec,
  output logic        en,
  output logic        start,
  output logic        irq
);

  logic        wr, rd, cr_wr, en_fall;
  logic [3:0]  widx;
  cr_t         cr;
  logic        busy, ccf, rderr, wrerr;
  logic        wr_inc, rd_inc, wr_wrap, rd_wrap, set_wrerr, set_rderr;
  logic [1:0]  wr_cnt, rd_cnt;
  logic [3:0]  wr_onehot, rd_onehot;
  logic [31:0] sr_word;
  logic        unused_bits;

  assign wr      = psel & penable & pwrite;
  assign rd      = psel & penable & ~pwrite;
  assign widx    = paddr[5:2];
  assign cr_wr   = wr & (widx == IDX_CR);
  // EN can only fall while idle, since CR writes during a block are restricted
  assign en_fall = cr_wr & ~busy & cr.en & ~pwdata[CR_EN];

  word_seq u_wr_seq (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (en_fall),
    .inc    (wr_inc),
    .cnt    (wr_cnt),
    .onehot (wr_onehot),
    .wrap   (wr_wrap)
  );

  word_seq u_rd_seq (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (en_fall | end_aes),
    .inc    (rd_inc),
    .cnt    (rd_cnt),
    .onehot (rd_onehot),
    .wrap   (rd_wrap)
  );

  assign unused_bits = ^{wr_cnt, rd_onehot};

  always_comb begin
    sr_word           = '0;
    sr_word[SR_CCF]   = ccf;
    sr_word[SR_RDERR] = rderr;
    sr_word[SR_WRERR] = wrerr;
    sr_word[SR_BUSY]  = busy;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path through
    // the decode below can infer a latch.
    col_en_host = '0;
    key_host_en = '0;
    iv_en       = '0;
    iv_sel_rd   = '0;
    prdata      = '0;
    pslverr     = 1'b0;
    wr_inc      = 1'b0;
    rd_inc      = 1'b0;
    set_wrerr   = 1'b0;
    set_rderr   = 1'b0;
    if (wr) begin
      case (widx)
        IDX_DINR: begin
          if (busy || ccf) begin
            pslverr   = 1'b1;
            set_wrerr = 1'b1;
          end else if (!cr.en) begin
            pslverr = 1'b1;
          end else begin
            col_en_host = wr_onehot;
            wr_inc      = 1'b1;
          end
        end
        default: begin
          if (widx[3:2] == GRP_KEYR || widx[3:2] == GRP_IVR) begin
            if (busy) begin
              pslverr   = 1'b1;
              set_wrerr = 1'b1;
            end else if (widx[3:2] == GRP_KEYR) begin
              key_host_en = onehot4(widx[1:0]);
            end else begin
              iv_en = onehot4(widx[1:0]);
            end
          end
        end
      endcase
    end
    if (rd) begin
      case (widx)
        IDX_CR: prdata = cr_word(cr);
        IDX_SR: prdata = sr_word;
        IDX_DOUTR: begin
          if (ccf) begin
            prdata = col_bus;
            rd_inc = 1'b1;
          end else begin
            pslverr   = 1'b1;
            set_rderr = 1'b1;
          end
        end
        default: begin
          if (widx[3:2] == GRP_IVR) begin
            iv_sel_rd = onehot4(widx[1:0]);
            prdata    = iv_bus;
          end
        end
      endcase
    end
  end

  // Flag sets are listed first so they win over a same-cycle clear request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cr    <= '0;
      busy  <= 1'b0;
      ccf   <= 1'b0;
      rderr <= 1'b0;
      wrerr <= 1'b0;
      start <= 1'b0;
      irq   <= 1'b0;
    end else begin
      start <= wr_wrap;
      if (cr_wr) begin
        cr.ccfie <= pwdata[CR_CCFIE];
        cr.errie <= pwdata[CR_ERRIE];
        if (!busy) begin
          cr.en        <= pwdata[CR_EN];
          cr.data_type <= pwdata[CR_DATATYPE +: 2];
          cr.mode      <= mode_e'(pwdata[CR_MODE +: 2]);
          cr.enc_dec   <= pwdata[CR_ENCDEC];
        end
      end
      if (wr_wrap)                  busy <= 1'b1;
      else if (end_aes || en_fall)  busy <= 1'b0;
      if (end_aes)                                               ccf <= 1'b1;
      else if (en_fall || rd_wrap || (cr_wr && pwdata[CR_CCFC])) ccf <= 1'b0;
      if (set_rderr)                         rderr <= 1'b1;
      else if (cr_wr && pwdata[CR_ERRC])     rderr <= 1'b0;
      if (set_wrerr)                         wrerr <= 1'b1;
      else if (cr_wr && pwdata[CR_ERRC])     wrerr <= 1'b0;
      irq <= (ccf & cr.ccfie) | ((rderr | wrerr) & cr.errie);
    end
  end

  assign pready       = 1'b1;
  assign bus_in       = pwdata;
  assign col_sel_host = rd_cnt;
  assign key_sel_rd   = 2'b00;
  assign en           = cr.en;
  assign data_type    = cr.data_type;
  assign mode         = cr.mode;
  assign enc_dec      = cr.enc_dec;

endmodule
